// File: rtl/videopll_pkg.sv
// Shared definitions for the video PLL lock controller: state codes and counter sizing.
package videopll_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    // Bits needed to count 0 .. max(a,b,c)-1 without wrapping inside any timed state.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/videopll_sync.sv
// Two-flop synchroniser for a single asynchronous PLL status bit, cleared by synchronous reset.
module videopll_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments let both flops sample their pre-edge values, giving two real stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/videopll_ctrl.sv
// Video PLL lock sequencer: pulses the PLL reset, waits for a stable lock, retries, and reports loss of lock.
module videopll_ctrl
    import videopll_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRY    = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       ready,
    output logic       fail,
    output logic [7:0] retry_cnt,
    output logic [7:0] lost_cnt,
    output logic [2:0] state
);

    localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               lock_s;
    logic               cnt_clr;
    logic               cnt_en;
    logic               retry_inc;
    logic               retry_clr;
    logic               lost_inc;
    logic               pll_rst_d;
    logic               ready_d;
    logic               fail_d;

    videopll_sync u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            pll_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= 8'd0;
            lost_cnt  <= 8'd0;
        end else begin
            state_q <= state_d;
            pll_rst <= pll_rst_d;
            ready   <= ready_d;
            fail    <= fail_d;

            if (cnt_clr)
                cnt_q <= '0;
            else if (cnt_en)
                cnt_q <= cnt_q + CNT_W'(1);

            if (retry_clr)
                retry_cnt <= 8'd0;
            else if (retry_inc)
                retry_cnt <= retry_cnt + 8'd1;

            if (lost_inc && lost_cnt != 8'hFF)
                lost_cnt <= lost_cnt + 8'd1;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d   = state_q;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        lost_inc  = 1'b0;

        if (restart) begin
            state_d   = ST_RESET;
            retry_clr = 1'b1;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (cnt_q == CNT_W'(RST_CYCLES - 1))
                        state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        retry_inc = 1'b1;
                        state_d   = (retry_cnt + 8'd1 == 8'(MAX_RETRY)) ? ST_FAIL : ST_RESET;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
                        state_d   = ST_RUN;
                        retry_clr = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d  = ST_RESET;
                        lost_inc = 1'b1;
                    end
                end
                ST_FAIL: ;
                default: state_d = ST_RESET;
            endcase
        end

        // Restart re-enters RESET from RESET too, so it must also restart the count.
        cnt_clr = restart || (state_d != state_q);
        cnt_en  = (state_q == ST_RESET) || (state_q == ST_WAIT_LOCK) || (state_q == ST_STABLE);
    end

    always_comb begin
        pll_rst_d = (state_d == ST_RESET) || (state_d == ST_FAIL);
        ready_d   = (state_d == ST_RUN);
        fail_d    = (state_d == ST_FAIL);
    end

    assign state = state_q;

endmodule

// File: tb/tb_videopll_ctrl.sv
// Self-checking bench for videopll_ctrl: directed scenarios with literal expectations plus random stimulus vs. a behavioural model.
module tb_videopll_ctrl;

    localparam int RST_C  = 4;
    localparam int TOUT_C = 20;
    localparam int STAB_C = 8;
    localparam int RETR_C = 2;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       restart = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       ready;
    logic       fail;
    logic [7:0] retry_cnt;
    logic [7:0] lost_cnt;
    logic [2:0] state;

    int n_checks = 0;
    int n_pass = 0;

    // Model: phase code, cycles spent in the phase, counters, and the 2-deep lock delay line.
    int       m_phase = 0;
    int       m_age = 0;
    int       m_retry = 0;
    int       m_lost = 0;
    logic [1:0] m_pipe = 2'b00;
    bit       m_valid = 1'b0;

    videopll_ctrl #(
        .RST_CYCLES   (RST_C),
        .LOCK_TIMEOUT (TOUT_C),
        .LOCK_STABLE  (STAB_C),
        .MAX_RETRY    (RETR_C)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .restart    (restart),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .lost_cnt   (lost_cnt),
        .state      (state)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        bit lock_now;
        int nxt;
        if (!rst_n) begin
            m_phase = 0;
            m_age   = 0;
            m_retry = 0;
            m_lost  = 0;
            m_pipe  = 2'b00;
            m_valid = 1'b1;
            return;
        end
        lock_now = m_pipe[1];
        m_pipe   = {m_pipe[0], pll_locked};
        nxt      = m_phase;
        if (restart) begin
            nxt     = 0;
            m_retry = 0;
        end else begin
            case (m_phase)
                0: if (m_age + 1 == RST_C) nxt = 1;
                1: begin
                    if (lock_now) nxt = 2;
                    else if (m_age + 1 == TOUT_C) begin
                        m_retry++;
                        nxt = (m_retry == RETR_C) ? 4 : 0;
                    end
                end
                2: begin
                    if (!lock_now) nxt = 1;
                    else if (m_age + 1 == STAB_C) begin
                        nxt     = 3;
                        m_retry = 0;
                    end
                end
                3: begin
                    if (!lock_now) begin
                        nxt = 0;
                        if (m_lost < 255) m_lost++;
                    end
                end
                default: ;
            endcase
        end
        m_age   = (restart || nxt != m_phase) ? 0 : m_age + 1;
        m_phase = nxt;
    endtask

    always @(posedge refclk) begin
        model_step();
        #2;
        if (m_valid) begin
            check("state", 8'(state), 8'(m_phase));
            check("pll_rst", 8'(pll_rst), 8'(m_phase == 0 || m_phase == 4));
            check("ready", 8'(ready), 8'(m_phase == 3));
            check("fail", 8'(fail), 8'(m_phase == 4));
            check("retry_cnt", retry_cnt, 8'(m_retry));
            check("lost_cnt", lost_cnt, 8'(m_lost));
        end
    end

    function automatic bit hit(input int which);
        case (which)
            0:       return ready === 1'b1;
            1:       return state === 3'd2;
            2:       return fail === 1'b1;
            3:       return pll_rst === 1'b0;
            default: return ready === 1'b0;
        endcase
    endfunction

    // Counts posedges until the condition holds (sampled 2 time units after each edge), bounded by limit.
    task automatic wait_until(input int which, input int limit, output int n);
        n = 0;
        do begin
            @(posedge refclk);
            #2;
            n++;
        end while (!hit(which) && n < limit);
        check("wait_hit", 8'(hit(which)), 8'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int level;

        repeat (3) @(negedge refclk);
        check("rst_state", 8'(state), 8'd0);
        check("rst_pll_rst", 8'(pll_rst), 8'd1);
        check("rst_ready", 8'(ready), 8'd0);
        check("rst_fail", 8'(fail), 8'd0);
        check("rst_retry", retry_cnt, 8'd0);
        check("rst_lost", lost_cnt, 8'd0);

        // Nominal: pll_rst falls on the 4th edge after release; lock 3 cycles later.
        rst_n = 1'b1;
        wait_until(3, 20, n);
        check("nom_rst_edges", 8'(n), 8'd4);
        repeat (3) @(negedge refclk);
        pll_locked = 1'b1;
        wait_until(0, 50, n);
        check("nom_lock_to_ready", 8'(n), 8'd11);
        check("nom_retry", retry_cnt, 8'd0);
        check("nom_state", 8'(state), 8'd3);

        // Loss in RUN: two sync stages, then the state leaves RUN on the following edge.
        @(negedge refclk) pll_locked = 1'b0;
        repeat (3) @(posedge refclk);
        #2;
        check("loss_state", 8'(state), 8'd0);
        check("loss_ready", 8'(ready), 8'd0);
        check("loss_pll_rst", 8'(pll_rst), 8'd1);
        check("loss_lost", lost_cnt, 8'd1);

        // Glitch after 5 stable cycles: back to WAIT_LOCK, then a full stable count.
        @(negedge refclk) pll_locked = 1'b1;
        wait_until(1, 50, n);
        repeat (5) @(posedge refclk);
        @(negedge refclk) pll_locked = 1'b0;
        @(negedge refclk) pll_locked = 1'b1;
        wait_until(0, 50, n);
        check("glitch_to_ready", 8'(n + 1), 8'd12);
        check("glitch_retry", retry_cnt, 8'd0);

        // Timeout twice -> FAIL on the 49th edge counting the restart edge.
        @(negedge refclk);
        restart    = 1'b1;
        pll_locked = 1'b0;
        @(negedge refclk) restart = 1'b0;
        wait_until(2, 200, n);
        check("tout_edges", 8'(n + 1), 8'd49);
        check("tout_state", 8'(state), 8'd4);
        check("tout_pll_rst", 8'(pll_rst), 8'd1);
        check("tout_retry", retry_cnt, 8'd2);
        check("tout_lost", lost_cnt, 8'd1);

        // Restart out of FAIL.
        @(negedge refclk) restart = 1'b1;
        @(posedge refclk);
        #2;
        check("fail_rs_state", 8'(state), 8'd0);
        check("fail_rs_fail", 8'(fail), 8'd0);
        check("fail_rs_pll_rst", 8'(pll_rst), 8'd1);
        check("fail_rs_retry", retry_cnt, 8'd0);

        // Restart on the very edge of the first WAIT_LOCK timeout (24th edge after restart).
        @(negedge refclk) restart = 1'b0;
        repeat (22) @(negedge refclk);
        @(negedge refclk) restart = 1'b1;
        @(posedge refclk);
        #2;
        check("prio_state", 8'(state), 8'd0);
        check("prio_retry", retry_cnt, 8'd0);
        check("prio_pll_rst", 8'(pll_rst), 8'd1);
        @(negedge refclk) restart = 1'b0;

        // Mid-run reset.
        pll_locked = 1'b1;
        wait_until(0, 100, n);
        @(negedge refclk) rst_n = 1'b0;
        @(posedge refclk);
        #2;
        check("mrst_state", 8'(state), 8'd0);
        check("mrst_pll_rst", 8'(pll_rst), 8'd1);
        check("mrst_ready", 8'(ready), 8'd0);
        check("mrst_lost", lost_cnt, 8'd0);
        @(negedge refclk) rst_n = 1'b1;
        wait_until(0, 50, n);
        check("mrst_to_ready", 8'(n), 8'd13);

        // Lost-lock counter saturation.
        for (int i = 0; i < 260; i++) begin
            @(negedge refclk) pll_locked = 1'b0;
            wait_until(4, 20, n);
            @(negedge refclk) pll_locked = 1'b1;
            wait_until(0, 60, n);
        end
        check("lost_sat", lost_cnt, 8'd255);

        // Random lock behaviour, restarts and resets against the model.
        level = 1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge refclk);
            if ($urandom_range(0, 59) == 0) level = 1 - level;
            pll_locked = (level == 1) && ($urandom_range(0, 59) != 0);
            restart    = ($urandom_range(0, 299) == 0);
            rst_n      = ($urandom_range(0, 599) != 0);
        end
        @(negedge refclk);
        restart = 1'b0;
        rst_n   = 1'b1;
        repeat (3) @(posedge refclk);
        #4;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
